// File: rtl/fp16_classify_accum.sv
// rtl/fp16_classify_accum.sv - fp16 result classifier with 2-deep output FIFO, sticky flags and event counters
module fp16_classify_accum (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_result,
    input  logic [3:0]  in_flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [9:0]  out_class,
    output logic [3:0]  out_flags,
    input  logic        csr_we,
    input  logic [3:0]  csr_wdata,
    output logic [3:0]  sticky_flags,
    input  logic        cnt_clr,
    output logic [7:0]  nan_count,
    output logic [7:0]  ovf_count
);

    localparam int FLAG_OF = 2;

    logic [1:0][15:0] r_res;
    logic [1:0][3:0]  r_flg;
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;
    logic             r_alive;
    logic [3:0]       r_sticky;
    logic [7:0]       r_nan_count;
    logic [7:0]       r_ovf_count;

    logic             w_accept;
    logic             w_pop;
    logic             w_in_nan;
    logic [15:0]      w_head_res;
    logic [3:0]       w_head_flg;

    // One-hot class: bits 0..7 run -inf..+inf, 8 sNaN, 9 qNaN.
    function automatic logic [9:0] f_classify(input logic [15:0] v);
        logic [9:0] c;
        c = '0;
        if (v[14:10] == 5'h1F) begin
            if (v[9:0] == 10'd0)
                c[v[15] ? 0 : 7] = 1'b1;
            else
                c[v[9] ? 9 : 8] = 1'b1;
        end else if (v[14:10] == 5'h00) begin
            if (v[9:0] == 10'd0)
                c[v[15] ? 3 : 4] = 1'b1;
            else
                c[v[15] ? 2 : 5] = 1'b1;
        end else begin
            c[v[15] ? 1 : 6] = 1'b1;
        end
        return c;
    endfunction

    // r_alive keeps in_ready low until the first clock edge after reset release.
    assign in_ready   = r_alive && (r_count < 2'd2);
    assign out_valid  = (r_count != 2'd0);
    assign w_accept   = in_valid && in_ready;
    assign w_pop      = out_valid && out_ready;
    assign w_in_nan   = (in_result[14:10] == 5'h1F) && (in_result[9:0] != 10'd0);
    assign w_head_res = r_res[r_head];
    assign w_head_flg = r_flg[r_head];

    always_comb begin
        out_result = '0;
        out_flags  = '0;
        out_class  = '0;
        if (out_valid) begin
            out_result = w_head_res;
            out_flags  = w_head_flg;
            out_class  = f_classify(w_head_res);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_res   <= '0;
            r_flg   <= '0;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_accept) begin
                r_res[r_tail] <= in_result;
                r_flg[r_tail] <= in_flags;
                r_tail        <= ~r_tail;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop};
        end
    end

    // A CSR write replaces the accumulated value but never drops flags arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sticky <= '0;
        end else if (csr_we) begin
            r_sticky <= csr_wdata | (w_accept ? in_flags : 4'h0);
        end else if (w_accept) begin
            r_sticky <= r_sticky | in_flags;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nan_count <= '0;
            r_ovf_count <= '0;
        end else if (cnt_clr) begin
            r_nan_count <= '0;
            r_ovf_count <= '0;
        end else begin
            if (w_accept && w_in_nan && (r_nan_count != 8'hFF))
                r_nan_count <= r_nan_count + 8'd1;
            if (w_accept && in_flags[FLAG_OF] && (r_ovf_count != 8'hFF))
                r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    assign sticky_flags = r_sticky;
    assign nan_count    = r_nan_count;
    assign ovf_count    = r_ovf_count;

endmodule

// File: tb/tb_fp16_classify_accum.sv
// tb/tb_fp16_classify_accum.sv - randomized and directed bench with a queue-based reference model
module tb_fp16_classify_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_result;
    logic [3:0]  in_flags;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [9:0]  out_class;
    logic [3:0]  out_flags;
    logic        csr_we;
    logic [3:0]  csr_wdata;
    logic [3:0]  sticky_flags;
    logic        cnt_clr;
    logic [7:0]  nan_count;
    logic [7:0]  ovf_count;

    fp16_classify_accum dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_flags(in_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_class(out_class), .out_flags(out_flags),
        .csr_we(csr_we), .csr_wdata(csr_wdata), .sticky_flags(sticky_flags),
        .cnt_clr(cnt_clr), .nan_count(nan_count), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: an entry list plus scalar state, updated from the spec rules.
    typedef struct packed { logic [15:0] res; logic [3:0] flg; } entry_t;
    entry_t m_q[$];
    bit       m_alive = 0;
    int       m_nan = 0;
    int       m_ovf = 0;
    int       m_sticky = 0;

    function automatic int class_index(input logic [15:0] v);
        int e;
        int m;
        bit neg;
        e   = int'(v[14:10]);
        m   = int'(v[9:0]);
        neg = v[15];
        if (e == 31 && m != 0) return (m >= 512) ? 9 : 8;
        if (e == 31)           return neg ? 0 : 7;
        if (e == 0 && m == 0)  return neg ? 3 : 4;
        if (e == 0)            return neg ? 2 : 5;
        return neg ? 1 : 6;
    endfunction

    initial forever begin
        bit acc;
        bit pop;
        @(posedge clk or posedge reset);
        if (reset) begin
            m_q.delete();
            m_alive  = 0;
            m_nan    = 0;
            m_ovf    = 0;
            m_sticky = 0;
        end else begin
            acc = in_valid && m_alive && (m_q.size() < 2);
            pop = (m_q.size() > 0) && out_ready;
            if (csr_we)   m_sticky = int'(csr_wdata) | (acc ? int'(in_flags) : 0);
            else if (acc) m_sticky = m_sticky | int'(in_flags);
            if (cnt_clr) begin
                m_nan = 0;
                m_ovf = 0;
            end else if (acc) begin
                if (class_index(in_result) >= 8) m_nan = (m_nan < 255) ? m_nan + 1 : 255;
                if (in_flags[2])                 m_ovf = (m_ovf < 255) ? m_ovf + 1 : 255;
            end
            if (pop) void'(m_q.pop_front());
            if (acc) m_q.push_back({in_result, in_flags});
            m_alive = 1;
        end
    end

    initial forever begin
        logic [15:0] er;
        logic [3:0]  ef;
        logic [9:0]  ec;
        @(negedge clk);
        er = '0; ef = '0; ec = '0;
        if (m_q.size() > 0) begin
            er = m_q[0].res;
            ef = m_q[0].flg;
            ec = 10'(1 << class_index(er));
        end
        check("m_out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check("m_in_ready", 32'(in_ready), 32'(m_alive && m_q.size() < 2));
        check("m_out_result", 32'(out_result), 32'(er));
        check("m_out_flags", 32'(out_flags), 32'(ef));
        check("m_out_class", 32'(out_class), 32'(ec));
        check("m_sticky", 32'(sticky_flags), 32'(m_sticky));
        check("m_nan_count", 32'(nan_count), 32'(m_nan));
        check("m_ovf_count", 32'(ovf_count), 32'(m_ovf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] cls_in  [6] = '{16'h0000, 16'h8000, 16'hFC00, 16'h7C01, 16'h03FF, 16'h83FF};
    logic [9:0]  cls_exp [6] = '{10'h010, 10'h008, 10'h001, 10'h100, 10'h020, 10'h004};

    initial begin
        reset = 1; in_valid = 0; in_result = 0; in_flags = 0; out_ready = 0;
        csr_we = 0; csr_wdata = 0; cnt_clr = 0;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_result", 32'(out_result), 0);
        check("rst_sticky", 32'(sticky_flags), 0);
        reset = 0;
        tick();
        check("rst_release_in_ready", 32'(in_ready), 1);

        // single op
        in_valid = 1; in_result = 16'h7C00; in_flags = 4'h4;
        tick();
        in_valid = 0;
        check("op_out_valid", 32'(out_valid), 1);
        check("op_class", 32'(out_class), 32'h080);
        check("op_sticky", 32'(sticky_flags), 4);
        check("op_ovf", 32'(ovf_count), 1);
        out_ready = 1; tick(); out_ready = 0;
        check("op_drained", 32'(out_valid), 0);

        // backpressure
        in_valid = 1; in_flags = 0; in_result = 16'h3C00; tick();
        in_result = 16'h8001; tick();
        in_result = 16'h7E00;
        check("bp_full_ready", 32'(in_ready), 0);
        tick();
        check("bp_hold_result", 32'(out_result), 32'h3C00);
        check("bp_hold_class", 32'(out_class), 32'h040);
        out_ready = 1; tick();
        check("bp_second", 32'(out_result), 32'h8001);
        check("bp_second_class", 32'(out_class), 32'h004);
        tick();
        in_valid = 0;
        check("bp_third", 32'(out_result), 32'h7E00);
        check("bp_third_class", 32'(out_class), 32'h200);
        tick();
        check("bp_empty", 32'(out_valid), 0);

        // classes, streaming with out_ready held
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; in_result = cls_in[i]; in_flags = 0;
            tick();
            check($sformatf("cls_%0d", i), 32'(out_class), 32'(cls_exp[i]));
        end
        in_valid = 0; tick();

        // sticky collision
        csr_we = 1; csr_wdata = 4'h9; tick();
        check("sticky_set9", 32'(sticky_flags), 9);
        csr_wdata = 4'h0; in_valid = 1; in_result = 16'h3C00; in_flags = 4'h2; tick();
        csr_we = 0; in_valid = 0;
        check("sticky_collision", 32'(sticky_flags), 2);

        // saturation and clear
        in_valid = 1; in_result = 16'h7E00; in_flags = 0;
        repeat (260) tick();
        check("nan_saturated", 32'(nan_count), 32'hFF);
        cnt_clr = 1; tick(); cnt_clr = 0; in_valid = 0;
        check("nan_cleared", 32'(nan_count), 0);
        check("ovf_cleared", 32'(ovf_count), 0);

        // reset mid-stream with full FIFO
        in_valid = 1; in_result = 16'h7C01; in_flags = 4'h4; out_ready = 0;
        tick(); tick();
        check("mid_full", 32'(in_ready), 0);
        reset = 1; #1;
        check("mid_out_valid", 32'(out_valid), 0);
        check("mid_nan", 32'(nan_count), 0);
        check("mid_ovf", 32'(ovf_count), 0);
        tick();
        reset = 0; in_valid = 0;
        tick();
        check("mid_release_ready", 32'(in_ready), 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_flags  = 4'($urandom);
            csr_we    = ($urandom_range(0, 15) == 0);
            csr_wdata = 4'($urandom);
            cnt_clr   = ($urandom_range(0, 63) == 0);
            case (sel)
                0:       in_result = {1'($urandom), 5'h1F, 10'd0};
                1:       in_result = {1'($urandom), 5'h1F, 10'($urandom_range(1, 1023))};
                2:       in_result = {1'($urandom), 5'h00, 10'($urandom)};
                3:       in_result = {1'($urandom), 15'd0};
                default: in_result = 16'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) begin
                reset = 1;
                tick();
                reset = 0;
            end
            tick();
        end
        in_valid = 0; csr_we = 0; cnt_clr = 0; out_ready = 1;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
